// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit logical shifter: moves at most STEP bit positions per clock behind a start/ready handshake.
// Optional `SHIFT_SEQ_ARITH_EN adds an 'arith' input for sign-filling right shifts.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [31:0]      shamt,
    input  logic             dir,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic             arith,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_q, d_d;
    logic             fill_q, fill_d;

    logic [CW-1:0]    cnt_init;
    logic [CW-1:0]    k;
    logic [CW-1:0]    cnt_rem;
    logic [WIDTH-1:0] shifted;
    logic             fill_in;

`ifdef SHIFT_SEQ_ARITH_EN
    assign fill_in = arith & A[WIDTH-1];
`else
    assign fill_in = 1'b0;
`endif

    // Full 32-bit compare so huge shift amounts never alias into a small count.
    assign cnt_init = (shamt >= 32'(WIDTH)) ? WIDTH_C : shamt[CW-1:0];
    assign k        = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    assign cnt_rem  = cnt_q - k;
    assign shifted  = d_q ? ((work_q >> k) | ({WIDTH{fill_q}} & ~({WIDTH{1'b1}} >> k)))
                          : (work_q << k);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d = A;
                    d_d    = dir;
                    fill_d = dir & fill_in;
                    cnt_d  = cnt_init;
                    if (cnt_init == '0) begin
                        res_d   = A;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_rem;
                if (cnt_rem == '0) begin
                    res_d   = shifted;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            fill_q  <= fill_d;
        end
    end

    assign ready = (state_q != SHIFT);
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign res   = res_q;

endmodule
